// File: rtl/debug_scan_pkg.sv
// debug_scan_pkg: shared FSM states, IR codes and default scan-chain length for the debug scan master
package debug_scan_pkg;
  typedef enum logic [2:0] {S_IDLE, S_UIR, S_CDR, S_SDR, S_UDR, S_RSP} state_e;
  localparam logic [1:0] IR_OCIMEM    = 2'b00;
  localparam logic [1:0] IR_TRACEMEM  = 2'b01;
  localparam logic [1:0] IR_BREAK     = 2'b10;
  localparam logic [1:0] IR_TRACECTRL = 2'b11;
  localparam int DR_W_DEF = 38;
endpackage

// File: rtl/cpu_debug_scan_tck_gen.sv
// cpu_debug_scan_tck_gen: divides clk into JTAG steps, producing tck and mid/end-of-step strobes
module cpu_debug_scan_tck_gen #(
  parameter int TCK_DIV = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic run_i,
  output logic tck_o,
  output logic step_mid_o,
  output logic step_end_o
);
  localparam int CW = $clog2(TCK_DIV);
  localparam logic [CW-1:0] HALF = CW'(TCK_DIV / 2);
  localparam logic [CW-1:0] LAST = CW'(TCK_DIV - 1);
  logic [CW-1:0] cnt_q, cnt_d;
  assign tck_o      = run_i && (cnt_q >= HALF);
  assign step_mid_o = run_i && (cnt_q == HALF);
  assign step_end_o = run_i && (cnt_q == LAST);
  // step counter restarts at every step boundary and idles at 0 so tck stays low outside a scan
  always_comb cnt_d = (!run_i || step_end_o) ? '0 : cnt_q + 1'b1;
  // step counter register
  always_ff @(posedge clk or posedge reset)
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
endmodule

// File: rtl/cpu_debug_scan_master.sv
// cpu_debug_scan_master: plays UIR/CDR/SDR/UDR virtual-JTAG sequences into the debug slave and returns the captured word
module cpu_debug_scan_master
  import debug_scan_pkg::*;
#(
  parameter int DR_W    = DR_W_DEF,
  parameter int TCK_DIV = 2
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            cmd_valid,
  output logic            cmd_ready,
  input  logic [1:0]      cmd_ir,
  input  logic [DR_W-1:0] cmd_dr,
  input  logic            cmd_skip_ir,
  output logic            rsp_valid,
  input  logic            rsp_ready,
  output logic [DR_W-1:0] rsp_data,
  output logic [1:0]      ir_in,
  output logic            tck,
  output logic            tdi,
  input  logic            tdo,
  output logic            vs_uir,
  output logic            vs_cdr,
  output logic            vs_sdr,
  output logic            vs_udr,
  output logic            jtag_state_rti
);
  localparam int BW = $clog2(DR_W + 1);
  state_e          state_q, state_d;
  logic [BW-1:0]   bit_q, bit_d;
  logic [DR_W-1:0] sr_q, sr_d;
  logic [1:0]      ir_q, ir_d;
  logic            tdo_q;
  logic            run, step_mid, step_end, shin, last_bit;
  assign run      = state_q inside {S_UIR, S_CDR, S_SDR, S_UDR};
  assign last_bit = bit_q == BW'(DR_W - 1);
  assign shin     = step_mid ? tdo : tdo_q;
  cpu_debug_scan_tck_gen #(.TCK_DIV(TCK_DIV)) u_tck (
    .clk        (clk),
    .reset      (reset),
    .run_i      (run),
    .tck_o      (tck),
    .step_mid_o (step_mid),
    .step_end_o (step_end)
  );
  assign cmd_ready      = state_q == S_IDLE;
  assign jtag_state_rti = state_q == S_IDLE;
  assign rsp_valid      = state_q == S_RSP;
  assign rsp_data       = sr_q;
  assign ir_in          = ir_q;
  assign tdi            = (state_q == S_SDR) && sr_q[0];
  assign vs_uir         = state_q == S_UIR;
  assign vs_cdr         = state_q == S_CDR;
  assign vs_sdr         = state_q == S_SDR;
  assign vs_udr         = state_q == S_UDR;
  // next-state: accept in IDLE, advance one virtual state per step, shift the chain during SDR
  always_comb begin
    state_d = state_q;
    bit_d   = bit_q;
    sr_d    = sr_q;
    ir_d    = ir_q;
    case (state_q)
      S_IDLE: if (cmd_valid) begin
        sr_d    = cmd_dr;
        ir_d    = cmd_skip_ir ? ir_q : cmd_ir;
        bit_d   = '0;
        state_d = cmd_skip_ir ? S_CDR : S_UIR;
      end
      S_UIR: state_d = step_end ? S_CDR : S_UIR;
      S_CDR: state_d = step_end ? S_SDR : S_CDR;
      S_SDR: if (step_end) begin
        sr_d    = {shin, sr_q[DR_W-1:1]};
        bit_d   = last_bit ? '0 : bit_q + 1'b1;
        state_d = last_bit ? S_UDR : S_SDR;
      end
      S_UDR: state_d = step_end ? S_RSP : S_UDR;
      S_RSP: state_d = rsp_ready ? S_IDLE : S_RSP;
      default: state_d = S_IDLE;
    endcase
  end
  // scan state registers; reset aborts any scan in progress and clears the captured data
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state_q <= S_IDLE;
      bit_q   <= '0;
      sr_q    <= '0;
      ir_q    <= '0;
    end else begin
      state_q <= state_d;
      bit_q   <= bit_d;
      sr_q    <= sr_d;
      ir_q    <= ir_d;
    end
  // tdo is captured at the tck rising point and shifted in at the following step end
  always_ff @(posedge clk or posedge reset)
    if (reset)         tdo_q <= 1'b0;
    else if (step_mid) tdo_q <= tdo;
endmodule
